// File: rtl/live_ratio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : live_ratio_pkg
// Description : Shared constants, FSM state type and checksum fold for the
//               live-ratio read-out path. Frame length and header marker
//               depend on LR_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package live_ratio_pkg;

  localparam logic [15:0] HDR_MARK    = 16'hA5A5;
  localparam logic [15:0] HDR_MARK_TS = 16'hA5A6;
  localparam logic [7:0]  TRL_MARK    = 8'h5A;

`ifdef LR_TIMESTAMP_EN
  localparam int          FRAME_LEN     = 5;
  localparam logic [15:0] HDR_MARK_USED = HDR_MARK_TS;
`else
  localparam int          FRAME_LEN     = 4;
  localparam logic [15:0] HDR_MARK_USED = HDR_MARK;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR  = 3'd2,
    ST_TS   = 3'd3,
    ST_NIN  = 3'd4,
    ST_NOUT = 3'd5,
    ST_TRL  = 3'd6
  } state_t;

  // Fold the running XOR of frame words into the 16-bit trailer checksum.
  function automatic logic [15:0] chk_fold(input logic [31:0] x);
    return x[31:16] ^ x[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/live_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : live_edge_detect
// Description : 4-bit live-gate shift register. Pulses o_start on 0011
//               (two low then two high) and o_end on 1100 (two high then
//               two low), so single-cycle glitches never fire either pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module live_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_live,
  output logic o_start,
  output logic o_end
);

  logic [3:0] r_sr;

  // Shift the live gate in at bit 0 every cycle.
  always_ff @(posedge clk) begin
    if (!rst) r_sr <= 4'b0000;
    else      r_sr <= {r_sr[2:0], i_live};
  end

  // Pattern decode straight off the shift register.
  always_comb begin
    o_start = (r_sr == 4'b0011);
    o_end   = (r_sr == 4'b1100);
  end

endmodule
`default_nettype wire

// File: rtl/live_ratio_reporter.sv
`default_nettype none
// ============================================================================
// Module      : live_ratio_reporter
// Description : Detects live end, waits SETTLE cycles, snapshots n_in/n_out
//               and ships one framed 32-bit word stream per spill over a
//               valid/ready link. Spill ends seen while a frame is pending
//               are counted as drops.
//               Optional macro LR_TIMESTAMP_EN adds a free-running cycle
//               timestamp word (TS) after the header.
// Revision    : 1.0 - initial release
// ============================================================================
module live_ratio_reporter
  import live_ratio_pkg::*;
#(
  parameter int SETTLE = 8,
  parameter int ID_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        live,
  input  logic [31:0] n_in,
  input  logic [31:0] n_out,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam int              CNT_W         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE - 1);
  localparam logic [ID_W-1:0]  c_id_one      = ID_W'(1);
  localparam logic [ID_W-1:0]  c_id_two      = ID_W'(2);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic [ID_W-1:0]   r_spill_id;
  logic [7:0]        r_drop_cnt;
  logic [7:0]        r_trl_drop;
  logic [31:0]       r_snap_in;
  logic [31:0]       r_snap_out;
  logic [15:0]       r_snap_id;
  logic [31:0]       r_chk_acc;
  logic [15:0]       w_id16;
  logic [7:0]        w_drop_inc;
  logic              w_detect;
  logic              w_live_start_unused;
  logic              w_xfer;
  logic              w_latch;

  live_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_live  (live),
    .o_start (w_live_start_unused),
    .o_end   (w_detect)
  );

  // Header carries exactly 16 bits of spill ID regardless of ID_W.
  generate
    if (ID_W >= 16) begin : g_id_trunc
      assign w_id16 = r_spill_id[15:0];
    end else begin : g_id_ext
      assign w_id16 = {{(16-ID_W){1'b0}}, r_spill_id};
    end
  endgenerate

  assign w_xfer     = out_valid && out_ready;
  assign w_latch    = (r_state == ST_WAIT) && (r_settle_cnt == '0);
  assign w_drop_inc = (r_drop_cnt == 8'hFF) ? 8'hFF : (r_drop_cnt + 8'd1);

`ifdef LR_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_snap_ts;

  // Free-running cycle counter, captured alongside the counter snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts      <= 32'd0;
      r_snap_ts <= 32'd0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_latch) r_snap_ts <= r_ts;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM next-state: word states only advance on an accepted transfer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_detect) w_next_state = ST_WAIT;
      ST_WAIT: if (r_settle_cnt == '0) w_next_state = ST_HDR;
`ifdef LR_TIMESTAMP_EN
      ST_HDR:  if (w_xfer) w_next_state = ST_TS;
      ST_TS:   if (w_xfer) w_next_state = ST_NIN;
`else
      ST_HDR:  if (w_xfer) w_next_state = ST_NIN;
`endif
      ST_NIN:  if (w_xfer) w_next_state = ST_NOUT;
      ST_NOUT: if (w_xfer) w_next_state = ST_TRL;
      ST_TRL:  if (w_xfer) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: every word is a pure function of state and frozen registers,
  // so it stays stable for as long as the sink stalls.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 32'd0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = {HDR_MARK_USED, r_snap_id};
      end
`ifdef LR_TIMESTAMP_EN
      ST_TS: begin
        out_valid = 1'b1;
        out_data  = r_snap_ts;
      end
`endif
      ST_NIN: begin
        out_valid = 1'b1;
        out_data  = r_snap_in;
      end
      ST_NOUT: begin
        out_valid = 1'b1;
        out_data  = r_snap_out;
      end
      ST_TRL: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {TRL_MARK, r_trl_drop, chk_fold(r_chk_acc)};
      end
      default: ;
    endcase
  end

  // Settle countdown, snapshot capture and running checksum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_settle_cnt <= '0;
      r_snap_in    <= 32'd0;
      r_snap_out   <= 32'd0;
      r_snap_id    <= 16'd0;
      r_chk_acc    <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && w_detect) begin
        r_settle_cnt <= c_settle_load;
      end else if (r_state == ST_WAIT && r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      if (w_latch) begin
        r_snap_in  <= n_in;
        r_snap_out <= n_out;
        r_snap_id  <= w_id16;
        r_chk_acc  <= 32'd0;
      end else if (w_xfer && !out_last) begin
        r_chk_acc  <= r_chk_acc ^ out_data;
      end
    end
  end

  // Spill ID and drop bookkeeping. The trailer drop field is frozen when
  // NOUT is accepted so the trailer word cannot change under a stall; any
  // spill end after that point still bumps spill_id but belongs to the frame
  // being finished and is cleared with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_spill_id <= '0;
      r_drop_cnt <= 8'd0;
      r_trl_drop <= 8'd0;
    end else begin
      if (w_xfer && out_last) begin
        r_drop_cnt <= 8'd0;
        r_spill_id <= r_spill_id + (w_detect ? c_id_two : c_id_one);
      end else if (w_detect && r_state != ST_IDLE) begin
        r_drop_cnt <= w_drop_inc;
        r_spill_id <= r_spill_id + c_id_one;
      end
      if (w_xfer && r_state == ST_NOUT) begin
        r_trl_drop <= w_detect ? w_drop_inc : r_drop_cnt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_live_ratio_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_live_ratio_reporter
// Description : Self-checking bench for live_ratio_reporter. A monitor
//               collects accepted words; each scenario compares them with
//               frames built from the spill ID, counter values and drop count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_live_ratio_reporter;

  localparam int SETTLE = 8;
`ifdef LR_TIMESTAMP_EN
  localparam int          FL      = 5;
  localparam logic [15:0] TB_MARK = 16'hA5A6;
`else
  localparam int          FL      = 4;
  localparam logic [15:0] TB_MARK = 16'hA5A5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        live = 1'b0;
  logic [31:0] n_in = 32'd0;
  logic [31:0] n_out = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int next_id = 0;
  logic [32:0] mon_q[$];

  live_ratio_reporter #(.SETTLE(SETTLE), .ID_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .live      (live),
    .n_in      (n_in),
    .n_out     (n_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: a word is accepted at the next rising edge when valid&ready
  // hold mid-cycle and reset is not asserted.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) mon_q.push_back({out_last, out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    live = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    mon_q.delete();
  endtask

  task automatic drive_spill(input int hi);
    live = 1'b1;
    repeat (hi) tick();
    live = 1'b0;
  endtask

  // Bounded wait for n collected words; rnd selects random ready per cycle.
  task automatic wait_words(input int n, input int budget, input bit rnd, output bit ok);
    int c = 0;
    while (mon_q.size() < n && c < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    ok = (mon_q.size() >= n);
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // Reference frame: header, [timestamp], counters, trailer whose checksum
  // folds the XOR of every earlier word.
  function automatic void model_frame(input logic [31:0] id, input logic [31:0] nin,
                                      input logic [31:0] nout, input logic [31:0] drop,
                                      input logic [31:0] ts, output logic [31:0] w [5]);
    logic [31:0] x;
    w[4] = 32'd0;
    w[0] = {TB_MARK, id[15:0]};
`ifdef LR_TIMESTAMP_EN
    w[1] = ts;
    w[2] = nin;
    w[3] = nout;
`else
    w[1] = nin;
    w[2] = nout;
    w[3] = ts & 32'd0;
`endif
    x = 32'd0;
    for (int k = 0; k < FL - 1; k++) x = x ^ w[k];
    w[FL-1] = {8'h5A, drop[7:0], x[31:16] ^ x[15:0]};
  endfunction

  function automatic logic [31:0] seen_ts();
`ifdef LR_TIMESTAMP_EN
    if (mon_q.size() > 1) return mon_q[1][31:0];
`endif
    return 32'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", out_last); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    mon_q.delete();
    next_id = 0;
  endtask

  task automatic test_basic_frame();
    logic [31:0] ew [5];
    int lat;
    bit ok;
    mon_q.delete();
    out_ready = 1'b1;
    n_in = 32'd100;
    n_out = 32'd96;
    drive_spill(50);
    wait_valid(40, lat);
    // two edges for the shift register to reach 1100, then SETTLE+1
    tests++; if (lat != SETTLE + 3) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, SETTLE + 3); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_words(FL, 30, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'(next_id), n_in, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL basic_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
`ifndef LR_TIMESTAMP_EN
      tests++; if (mon_q[3][31:0] !== 32'h5A00A5A1) begin fails++; $display("FAIL basic_trailer_const: got %h want 5a00a5a1", mon_q[3][31:0]); end
`endif
    end
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_after: busy=%b valid=%b want 0/0", busy, out_valid); end
    next_id++;
  endtask

  task automatic test_backpressure();
    logic [31:0] ew [5];
    logic pv, pr, pl;
    logic [31:0] pd;
    int cyc = 0;
    mon_q.delete();
    out_ready = 1'b0;
    n_in = $urandom;
    n_out = $urandom;
    drive_spill(10);
    while (mon_q.size() < FL && cyc < 300) begin
      out_ready = ((cyc / 3) % 2) == 1;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      tick();
      cyc++;
      if (pv && !pr) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          fails++; $display("FAIL bp_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
        end
      end
    end
    out_ready = 1'b1;
    repeat (20) tick();
    tests++; if (mon_q.size() != FL) begin fails++; $display("FAIL bp_count: got %0d words want %0d", mon_q.size(), FL); end
    if (mon_q.size() == FL) begin
      model_frame(32'(next_id), n_in, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL bp_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    next_id++;
  endtask

  task automatic test_glitch();
    logic [31:0] ew [5];
    bit ok;
    do_reset();
    next_id = 0;
    out_ready = 1'b1;
    n_in = 32'h0000_1111;
    n_out = 32'h0000_0F0F;
    live = 1'b1; repeat (20) tick();
    live = 1'b0; tick();
    live = 1'b1; repeat (20) tick();
    tests++; if (mon_q.size() != 0) begin fails++; $display("FAIL glitch_noframe: got %0d words want 0", mon_q.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b want 0", busy); end
    live = 1'b0;
    wait_words(FL, 60, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL glitch_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'd0, n_in, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL glitch_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    next_id = 1;
  endtask

  task automatic test_drop_counting();
    logic [31:0] ew [5];
    int lat;
    bit ok;
    do_reset();
    out_ready = 1'b0;
    n_in = 32'd7;
    n_out = 32'd5;
    drive_spill(10);
    wait_valid(40, lat);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drop_hdr_timeout: valid=%b want 1", out_valid); end
    repeat (3) begin
      drive_spill(4);
      repeat (4) tick();
    end
    tests++; if (out_data !== {TB_MARK, 16'd0} || busy !== 1'b1) begin
      fails++; $display("FAIL drop_hdr_hold: got %h busy=%b want %h busy=1", out_data, busy, {TB_MARK, 16'd0});
    end
    out_ready = 1'b1;
    wait_words(FL, 30, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'd0, n_in, n_out, 32'd3, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL drop_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    // one frame plus three dropped spills: the next spill is number four
    mon_q.delete();
    repeat (3) tick();
    n_in = 32'hDEAD_0001;
    n_out = 32'hBEEF_0002;
    drive_spill(6);
    wait_words(FL, 60, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_next_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'd4, n_in, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL drop_next_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    next_id = 5;
  endtask

  task automatic test_snapshot();
    logic [31:0] ew [5];
    logic [31:0] pre;
    int lat;
    bit ok;
    mon_q.delete();
    out_ready = 1'b1;
    pre = 32'h1234_5678;
    n_in = pre;
    n_out = 32'h0000_4321;
    drive_spill(8);
    wait_valid(40, lat);
    n_in = 32'hFFFF_FFFF;
    wait_words(FL, 30, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL snap_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'(next_id), pre, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL snap_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    next_id++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ew [5];
    int lat;
    bit ok;
    mon_q.delete();
    out_ready = 1'b1;
    n_in = 32'hAAAA_5555;
    n_out = 32'h5555_AAAA;
    drive_spill(8);
    wait_valid(40, lat);
`ifdef LR_TIMESTAMP_EN
    tick();
`endif
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== n_in) begin
      fails++; $display("FAIL rstmid_nin: got v=%b d=%h want v=1 d=%h", out_valid, out_data, n_in);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    repeat (5) tick();
    tests++; if (mon_q.size() != FL - 3) begin fails++; $display("FAIL rstmid_partial: got %0d words want %0d", mon_q.size(), FL - 3); end
    mon_q.delete();
    drive_spill(8);
    wait_words(FL, 60, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_timeout: got %0d words want %0d", mon_q.size(), FL); end
    if (ok) begin
      model_frame(32'd0, n_in, n_out, 32'd0, seen_ts(), ew);
      for (int k = 0; k < FL; k++) begin
        tests++;
        if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
          fails++; $display("FAIL rstmid_word%0d: got %h want %h", k, mon_q[k], {(k == FL - 1), ew[k]});
        end
      end
    end
    next_id = 1;
  endtask

  task automatic test_random();
    logic [31:0] ew [5];
    bit ok;
    for (int it = 0; it < 8; it++) begin
      mon_q.delete();
      n_in = $urandom;
      n_out = $urandom;
      repeat ($urandom_range(1, 6)) tick();
      drive_spill($urandom_range(2, 30));
      wait_words(FL, 300, 1'b1, ok);
      out_ready = 1'b1;
      repeat (3) tick();
      tests++; if (!ok || mon_q.size() != FL) begin fails++; $display("FAIL rand%0d_count: got %0d words want %0d", it, mon_q.size(), FL); end
      if (mon_q.size() == FL) begin
        model_frame(32'(next_id), n_in, n_out, 32'd0, seen_ts(), ew);
        for (int k = 0; k < FL; k++) begin
          tests++;
          if (mon_q[k] !== {(k == FL - 1), ew[k]}) begin
            fails++; $display("FAIL rand%0d_word%0d: got %h want %h", it, k, mon_q[k], {(k == FL - 1), ew[k]});
          end
        end
      end
      next_id++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_glitch();
    test_drop_counting();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
